// File: rtl/vram_image_loader_if.sv
// vram_image_loader_if
// Byte-wide valid/ready write port into VRAM.
//   vram_address : 17-bit byte address of the write
//   vram_wdata   : 8-bit write data
//   vram_valid   : write request, held until accepted
//   vram_ready   : sink accepts the write when vram_valid && vram_ready
// master modport: the copy engine that issues writes.
// slave modport : the VRAM sink that accepts them.
interface vram_image_loader_if;
  logic [16:0] vram_address;
  logic [7:0]  vram_wdata;
  logic        vram_valid;
  logic        vram_ready;

  modport master (
    output vram_address,
    output vram_wdata,
    output vram_valid,
    input  vram_ready
  );

  modport slave (
    input  vram_address,
    input  vram_wdata,
    input  vram_valid,
    output vram_ready
  );
endinterface

// File: rtl/vram_image_loader.sv
// vram_image_loader
// Copies LENGTH bytes from the registered-output image ROM into VRAM,
// starting at VRAM byte address BASE_ADR. Each byte walks through
// READ (ROM address presented), LATCH (ROM data captured) and WRITE
// (request held until the sink accepts it).
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   start        : one-cycle run request, honoured only while idle
//   busy         : a transfer is in progress
//   done         : one-cycle pulse after the final accepted write
//   rom_adr      : ROM address, equals the byte counter
//   rom_dbi      : ROM data, valid one cycle after rom_adr
//   vram         : write port (address, data, valid, ready)
// Every output comes straight from a register.
module vram_image_loader #(
  parameter logic [16:0] BASE_ADR = 17'h00000,
  parameter int unsigned LENGTH   = 16384
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [13:0]                rom_adr,
  input  logic [7:0]                 rom_dbi,
  vram_image_loader_if.master        vram
);

  localparam logic [14:0] LAST_CNT = 15'(LENGTH - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_LATCH = 2'b10,
    ST_WRITE = 2'b11
  } state_t;

  state_t      state_r,        state_nxt_s;
  logic [14:0] cnt_r,          cnt_nxt_s;
  logic        busy_r,         busy_nxt_s;
  logic        done_r,         done_nxt_s;
  logic [13:0] rom_adr_r,      rom_adr_nxt_s;
  logic [16:0] vram_address_r, vram_address_nxt_s;
  logic [7:0]  vram_wdata_r,   vram_wdata_nxt_s;
  logic        vram_valid_r,   vram_valid_nxt_s;

  logic [14:0] cnt_inc_s;
  logic [16:0] addr_sum_s;

  // Counter increment and VRAM address; the 17-bit sum wraps naturally.
  assign cnt_inc_s  = cnt_r + 15'd1;
  assign addr_sum_s = BASE_ADR + {2'b00, cnt_r};

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= ST_IDLE;
      cnt_r          <= 15'd0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      rom_adr_r      <= 14'd0;
      vram_address_r <= BASE_ADR;
      vram_wdata_r   <= 8'd0;
      vram_valid_r   <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      cnt_r          <= cnt_nxt_s;
      busy_r         <= busy_nxt_s;
      done_r         <= done_nxt_s;
      rom_adr_r      <= rom_adr_nxt_s;
      vram_address_r <= vram_address_nxt_s;
      vram_wdata_r   <= vram_wdata_nxt_s;
      vram_valid_r   <= vram_valid_nxt_s;
    end
  end

  // Next-state and next-output decode for the copy sequencer.
  always_comb begin
    state_nxt_s        = state_r;
    cnt_nxt_s          = cnt_r;
    busy_nxt_s         = busy_r;
    done_nxt_s         = 1'b0;
    rom_adr_nxt_s      = rom_adr_r;
    vram_address_nxt_s = vram_address_r;
    vram_wdata_nxt_s   = vram_wdata_r;
    vram_valid_nxt_s   = vram_valid_r;

    case (state_r)
      ST_IDLE: begin
        // The FSM is already idle while done is high, but that cycle still
        // belongs to the finishing run, so a start seen there is dropped.
        if (start && !done_r) begin
          cnt_nxt_s     = 15'd0;
          rom_adr_nxt_s = 14'd0;
          busy_nxt_s    = 1'b1;
          state_nxt_s   = ST_READ;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end

      ST_READ: begin
        // rom_adr is stable; the ROM registers it at the end of this cycle.
        state_nxt_s = ST_LATCH;
      end

      ST_LATCH: begin
        vram_wdata_nxt_s   = rom_dbi;
        vram_address_nxt_s = addr_sum_s;
        vram_valid_nxt_s   = 1'b1;
        state_nxt_s        = ST_WRITE;
      end

      ST_WRITE: begin
        if (vram.vram_ready) begin
          vram_valid_nxt_s = 1'b0;
          if (cnt_r == LAST_CNT) begin
            done_nxt_s  = 1'b1;
            busy_nxt_s  = 1'b0;
            state_nxt_s = ST_IDLE;
          end else begin
            // The ROM address only moves on entry to READ.
            cnt_nxt_s     = cnt_inc_s;
            rom_adr_nxt_s = cnt_inc_s[13:0];
            state_nxt_s   = ST_READ;
          end
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end

      default: begin
        state_nxt_s      = ST_IDLE;
        busy_nxt_s       = 1'b0;
        vram_valid_nxt_s = 1'b0;
      end
    endcase
  end

  assign busy              = busy_r;
  assign done              = done_r;
  assign rom_adr           = rom_adr_r;
  assign vram.vram_address = vram_address_r;
  assign vram.vram_wdata   = vram_wdata_r;
  assign vram.vram_valid   = vram_valid_r;

endmodule
